stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (1..64).
REQ-002 SHALL have parameter NUM_CH, default 8, number of output channels (2..32).
REQ-003 SHALL have derived localparam SEL_W = $clog2(NUM_CH), which is not overridable.
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, upstream beat present.
REQ-007 SHALL have port in_ready, output, 1, beat accepted when in_valid && in_ready at a clk edge.
REQ-008 SHALL have port in_data, input, DATA_W, the payload.
REQ-009 SHALL have port in_sel, input, SEL_W, the destination channel index.
REQ-010 SHALL have port in_bcast, input, 1, which delivers the beat to all channels and causes in_sel to be ignored.
REQ-011 SHALL have port out_valid, output, NUM_CH, one bit per channel.
REQ-012 SHALL have port out_ready, input, NUM_CH, one bit per channel.
REQ-013 SHALL have port out_data, output, NUM_CH*DATA_W, with channel k at bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have port drop_cnt, output, 16, the count of discarded out-of-range beats.

Function
REQ-015 SHALL give each channel a one-entry slot with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 Slot EMPTY->FULL SHALL occur on load; FULL->EMPTY on out_ready without load; FULL->FULL on out_ready with load (new data); FULL without out_ready SHALL hold data stable.
REQ-017 Channel k SHALL be "free" when EMPTY, or when FULL and out_ready[k]=1 in the same cycle.
REQ-018 Unicast (in_bcast=0, in_sel<NUM_CH): in_ready SHALL equal free[in_sel], and acceptance SHALL load only slot in_sel.
REQ-019 Broadcast (in_bcast=1): in_ready SHALL be the AND of all free[k], and acceptance SHALL load every slot with in_data, all-or-nothing with no partial delivery.
REQ-020 Out-of-range (in_bcast=0, in_sel>=NUM_CH, possible only when NUM_CH is not a power of 2): in_ready SHALL be 1, the beat SHALL be discarded, and no slot SHALL change.
REQ-021 Latency SHALL be 1 cycle: a beat accepted at edge N SHALL show out_valid/out_data from edge N; no combinational path in_data->out_data.
REQ-022 in_ready SHALL depend combinationally only on in_valid-independent state, in_sel, in_bcast and out_ready; in_ready SHALL NOT depend on in_valid.
REQ-023 A FULL slot with out_ready=0 SHALL NOT be overwritten under any input.
REQ-024 Throughput SHALL be 1 beat/cycle per channel when that channel's out_ready is held at 1.

Reset
REQ-025 While rst=1, all slots SHALL be EMPTY, out_valid SHALL be 0, out_data SHALL be 0 and drop_cnt SHALL be 0, taking effect immediately without a clock edge.
REQ-026 Reset asserted mid-transfer SHALL discard all held beats; after release the first edge SHALL accept normally.

Configuration
REQ-027 Macro STREAM_DEMUX_DROP_CNT_EN defined: drop_cnt SHALL increment by 1 per discarded out-of-range beat, saturating at 16'hFFFF.
REQ-028 Macro STREAM_DEMUX_DROP_CNT_EN undefined: drop_cnt SHALL be tied to 0, no counter flops SHALL exist, and discard behaviour SHALL be unchanged.

Structure
REQ-029 Package stream_demux_pkg SHALL hold the slot state enum (SLOT_EMPTY, SLOT_FULL), DROP_CNT_W=16 and default DATA_W/NUM_CH constants.
REQ-030 Sub-module stream_demux_slot (one-entry buffer: load, data_in, ready_in, valid_out, data_out, free_out), generated NUM_CH times, SHALL implement REQ-015..REQ-017.

Verification
REQ-031 DATA_W=8, NUM_CH=8: unicast sel=3 data=8'hA5, all out_ready=1 -> out_valid=8'b0000_1000 with ch3 data=A5 after one edge; slot empty on the next edge.
REQ-032 out_ready[5]=0; send sel=5 data=8'h11 then sel=5 data=8'h22 -> second beat sees in_ready=0; ch5 holds 8'h11 until out_ready[5]=1, then 8'h22 loads on that same edge.
REQ-033 Broadcast data=8'h3C with out_ready[2]=0 and slot 2 FULL -> in_ready=0, no slot changes; raising out_ready[2] -> all 8 slots load 3C on one edge.
REQ-034 NUM_CH=6: sel=6 and sel=7, three beats each -> in_ready=1, no out_valid; drop_cnt=6 with STREAM_DEMUX_DROP_CNT_EN, 0 without.
REQ-035 Four channels FULL and stalled; assert rst between edges -> out_valid=0, drop_cnt=0 immediately; after release, sel=0 data=8'h01 delivered in 1 cycle.
REQ-036 Random unicast/broadcast traffic with random out_ready for 10k cycles -> the per-channel scoreboard SHALL show no loss, duplication or reordering, and every stall cycle SHALL show stable out_data.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
// Optional drop counter is enabled by defining STREAM_DEMUX_DROP_CNT_EN.
package stream_demux_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int DROP_CNT_W     = 16;
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_NUM_CH = 8;

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output buffer for a single demux channel.
// valid_out is the slot state; free_out says a load may be taken this cycle.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              free_out
);

    slot_state_t       state;
    logic [DATA_W-1:0] data_q;
    logic              load_ok;

    assign free_out  = (state == SLOT_EMPTY) || ready_in;
    // A stalled full slot must never be overwritten, whatever the caller asks.
    assign load_ok   = load && free_out;
    assign valid_out = (state == SLOT_FULL);
    assign data_out  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SLOT_EMPTY;
            data_q <= '0;
        end else if (load_ok) begin
            state  <= SLOT_FULL;
            data_q <= data_in;
        end else if (ready_in) begin
            state  <= SLOT_EMPTY;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Routes a valid/ready stream to one of NUM_CH channels or broadcasts to all.
// Define STREAM_DEMUX_DROP_CNT_EN to count discarded out-of-range beats.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int NUM_CH = DEFAULT_NUM_CH,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    // Handshake: a beat transfers on a rising edge where valid && ready;
    // ready never looks at valid, and valid never waits on ready.

    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] load;
    logic              sel_free;
    logic              accept;

    // Out-of-range selects fall through to the default of 1 and are discarded.
    always_comb begin
        sel_free = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == SEL_W'(k)) sel_free = free[k];
        end
    end

    assign in_ready = in_bcast ? (&free) : sel_free;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign load[k] = accept && (in_bcast || (in_sel == SEL_W'(k)));

        stream_demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .data_in  (in_data),
            .ready_in (out_ready[k]),
            .valid_out(out_valid[k]),
            .data_out (out_data[k*DATA_W +: DATA_W]),
            .free_out (free[k])
        );
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic                  in_range;
    logic                  drop;
    logic [DROP_CNT_W-1:0] drop_q;

    always_comb begin
        in_range = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == SEL_W'(k)) in_range = 1'b1;
        end
    end

    assign drop = in_valid && !in_bcast && !in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed and random checks of stream_demux against a per-channel queue model.
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst;
    // 8-channel instance
    logic        iv, ibc, irdy;
    logic [2:0]  isel;
    logic [7:0]  idata;
    logic [7:0]  ov, ordy;
    logic [63:0] od;
    logic [15:0] dcnt;
    // 6-channel instance for out-of-range selects
    logic        b_iv, b_irdy;
    logic [2:0]  b_sel;
    logic [7:0]  b_data;
    logic [5:0]  b_ov, b_ordy;
    logic [47:0] b_od;
    logic [15:0] b_dcnt;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[8][$];

    always #5 clk = ~clk;

    stream_demux #(.DATA_W(8), .NUM_CH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(irdy), .in_data(idata),
        .in_sel(isel), .in_bcast(ibc), .out_valid(ov), .out_ready(ordy),
        .out_data(od), .drop_cnt(dcnt)
    );

    stream_demux #(.DATA_W(8), .NUM_CH(6)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_irdy), .in_data(b_data),
        .in_sel(b_sel), .in_bcast(1'b0), .out_valid(b_ov), .out_ready(b_ordy),
        .out_data(b_od), .drop_cnt(b_dcnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        logic all_free = 1'b1;
        logic f [8];
        for (int k = 0; k < 8; k++) begin
            f[k] = (exp_q[k].size() == 0) || ordy[k];
            all_free &= f[k];
        end
        return ibc ? all_free : f[isel];
    endfunction

    // Model: a channel holds at most one beat; it leaves when out_ready is
    // seen at an edge, and accepted beats join the selected queue(s).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) exp_q[k].delete();
        end else begin
            logic acc;
            acc = iv && model_ready();
            for (int k = 0; k < 8; k++)
                if (exp_q[k].size() > 0 && ordy[k]) void'(exp_q[k].pop_front());
            if (acc) begin
                for (int k = 0; k < 8; k++)
                    if (ibc || isel == 3'(k)) exp_q[k].push_back(idata);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 64'(irdy), 64'(model_ready()));
            for (int k = 0; k < 8; k++) begin
                check($sformatf("out_valid[%0d]", k), 64'(ov[k]), 64'(exp_q[k].size() > 0));
                if (exp_q[k].size() > 0)
                    check($sformatf("out_data[%0d]", k), 64'(od[k*8 +: 8]), 64'(exp_q[k][0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        iv = 0; ibc = 0; isel = 0; idata = 0; ordy = 0;
        b_iv = 0; b_sel = 0; b_data = 0; b_ordy = 6'h3F;
        #3;
        check("reset out_valid", 64'(ov), 64'h0);
        check("reset out_data", od, 64'h0);
        check("reset drop_cnt", 64'(dcnt), 64'h0);
        repeat (2) step();
        rst = 1'b0;

        // Unicast to ch3 with everything ready
        ordy = 8'hFF; iv = 1; isel = 3; idata = 8'hA5;
        #1 check("uni in_ready", 64'(irdy), 64'h1);
        step(); iv = 0;
        check("uni out_valid", 64'(ov), 64'h08);
        check("uni ch3 data", 64'(od[31:24]), 64'hA5);
        step();
        check("uni drained", 64'(ov), 64'h0);

        // Stalled ch5: second beat waits and loads on the releasing edge
        ordy = 8'hDF; iv = 1; isel = 5; idata = 8'h11;
        step(); idata = 8'h22;
        #1 check("stall in_ready", 64'(irdy), 64'h0);
        step();
        check("stall hold valid", 64'(ov[5]), 64'h1);
        check("stall hold data", 64'(od[47:40]), 64'h11);
        ordy[5] = 1'b1;
        #1 check("release in_ready", 64'(irdy), 64'h1);
        step(); iv = 0;
        check("release ch5 data", 64'(od[47:40]), 64'h22);
        check("release ch5 valid", 64'(ov), 64'h20);
        step();
        check("release drained", 64'(ov), 64'h0);

        // Broadcast blocked by a stalled full ch2, then all-or-nothing load
        ordy = 8'hFB; iv = 1; isel = 2; idata = 8'h77;
        step(); ibc = 1; idata = 8'h3C;
        #1 check("bcast blocked", 64'(irdy), 64'h0);
        step();
        check("bcast no partial", 64'(ov), 64'h04);
        check("bcast ch2 kept", 64'(od[23:16]), 64'h77);
        ordy[2] = 1'b1;
        #1 check("bcast open", 64'(irdy), 64'h1);
        step(); iv = 0; ibc = 0;
        check("bcast all valid", 64'(ov), 64'hFF);
        check("bcast all data", od, 64'h3C3C3C3C3C3C3C3C);
        step();

        // Out-of-range selects on the 6-channel instance
        b_iv = 1;
        for (int i = 0; i < 6; i++) begin
            b_sel = (i % 2 == 0) ? 3'd6 : 3'd7;
            b_data = 8'(i);
            #1 check("oor in_ready", 64'(b_irdy), 64'h1);
            step();
            check("oor no out_valid", 64'(b_ov), 64'h0);
        end
        b_iv = 0;
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("drop_cnt", 64'(b_dcnt), 64'd6);
`else
        check("drop_cnt", 64'(b_dcnt), 64'd0);
`endif
        check("in-range drop_cnt", 64'(dcnt), 64'h0);

        // Reset mid-transfer with four stalled channels
        ordy = 8'h00; iv = 1;
        for (int i = 0; i < 4; i++) begin
            isel = 3'(i); idata = 8'hF0 + 8'(i);
            step();
        end
        iv = 0;
        check("four full", 64'(ov), 64'h0F);
        #1 rst = 1'b1;
        #1;
        check("async rst valid", 64'(ov), 64'h0);
        check("async rst data", od, 64'h0);
        check("async rst drop", 64'(b_dcnt), 64'h0);
        #2 rst = 1'b0;
        ordy = 8'hFF; iv = 1; isel = 0; idata = 8'h01;
        step(); iv = 0;
        check("post rst valid", 64'(ov), 64'h01);
        check("post rst data", 64'(od[7:0]), 64'h01);
        step();

        // Random traffic: the model and per-cycle compare do the checking
        for (int c = 0; c < 10000; c++) begin
            iv    = ($urandom_range(0, 3) != 0);
            ibc   = ($urandom_range(0, 7) == 0);
            isel  = 3'($urandom_range(0, 7));
            idata = 8'($urandom_range(0, 255));
            ordy  = 8'($urandom_range(0, 255)) | 8'($urandom_range(0, 255));
            step();
        end
        iv = 0; ibc = 0; ordy = 8'hFF;
        step(); step();
        check("final empty", 64'(ov), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
